// File: rtl/fifo_pkt_writer_pkg.sv
// Shared definitions for the router input-FIFO packet writer: FSM states,
// header field positions and the default fill byte.
package fifo_pkt_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PAD    = 3'd2,
        S_COMMIT = 3'd3,
        S_DROP   = 3'd4
    } state_t;

    localparam int DEST_MSB = 7;
    localparam int DEST_LSB = 4;
    localparam int LEN_MSB  = 3;
    localparam int LEN_LSB  = 0;

    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    function automatic int hdr_len(input logic [7:0] hdr);
        return int'(hdr[LEN_MSB:LEN_LSB]);
    endfunction

endpackage

// File: rtl/fifo_pkt_writer_xor.sv
// pkt_xor_check: running XOR over a packet, seeded by the header byte and
// compared against the final (checksum) byte. Used only with ROUTER_PKT_CHECKSUM_EN.
module pkt_xor_check #(
    parameter int UWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_last,
    input  logic [UWIDTH-1:0] i_hdr,
    input  logic [UWIDTH-1:0] i_data,
    output logic              o_bad
);

    logic [UWIDTH-1:0] r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_acc <= '0;
        else if (i_clear)          r_acc <= i_hdr;
        else if (i_en && !i_last)  r_acc <= r_acc ^ i_data;
    end

    assign o_bad = i_en & i_last & (r_acc != i_data);

endmodule

// File: rtl/fifo_pkt_writer.sv
// Packet writer in front of the router input FIFO: stores one packet per entry,
// pads it to WIDTH bytes and commits with winc. Option: ROUTER_PKT_CHECKSUM_EN.
module fifo_pkt_writer
    import fifo_pkt_writer_pkg::*;
#(
    parameter int                WIDTH     = 11,
    parameter int                UWIDTH    = 8,
    parameter int                PTR_IN_SZ = 4,
    parameter logic [UWIDTH-1:0] PAD_BYTE  = UWIDTH'(DEF_PAD_BYTE),
    parameter int                CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [UWIDTH-1:0]    in_data,
    output logic                 in_ready,
    input  logic                 wfull,
    output logic [UWIDTH-1:0]    wdata,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic                 wbyte_we,
    output logic                 winc,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH - 1);

    state_t                 r_state, w_nxt;
    logic [PTR_IN_SZ-1:0]   r_idx, w_idx_nxt;
    logic [PTR_IN_SZ-1:0]   r_len;
    logic                   r_live;
    logic [CNT_W-1:0]       r_pkt_cnt, r_drop_cnt;

    logic                   w_ready, w_acc, w_hdr_take, w_hdr_ok, w_len_bad, w_ck_bad;
    logic                   w_we, w_winc, w_pkt_inc;
    logic [1:0]             w_drop_inc;
    logic [UWIDTH-1:0]      w_wdata;
    logic [PTR_IN_SZ-1:0]   w_addr;
    logic [CNT_W:0]         w_drop_sum;
    int                     w_len;

    assign w_len     = hdr_len(in_data[7:0]);
    assign w_len_bad = (w_len > WIDTH - 1);
`ifdef ROUTER_PKT_CHECKSUM_EN
    assign w_hdr_ok  = !w_len_bad && (w_len != 0);
`else
    assign w_hdr_ok  = !w_len_bad;
`endif

    // r_live holds in_ready low until the first clock after reset release
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = !wfull;
            S_LOAD:  w_ready = 1'b1;
            S_DROP:  w_ready = !(in_sop && wfull);
            default: w_ready = 1'b0;
        endcase
        w_ready = w_ready & r_live;
    end

    assign w_acc = in_valid & w_ready;

    always_comb begin
        w_nxt      = r_state;
        w_idx_nxt  = r_idx;
        w_we       = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_winc     = 1'b0;
        w_pkt_inc  = 1'b0;
        w_drop_inc = 2'd0;
        w_hdr_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (in_sop) w_hdr_take = 1'b1;
                    else        w_drop_inc = 2'd1;
                end
            end
            S_LOAD: begin
                if (w_acc && in_sop) begin
                    w_hdr_take = 1'b1;
                    w_drop_inc = 2'd1;
                end else if (w_acc) begin
                    w_we      = 1'b1;
                    w_addr    = r_idx;
                    w_wdata   = in_data;
                    w_idx_nxt = r_idx + PTR_IN_SZ'(1);
                    if (r_idx == r_len) begin
                        if (w_ck_bad) begin
                            w_nxt      = S_IDLE;
                            w_drop_inc = 2'd1;
                            w_idx_nxt  = '0;
                        end else if (r_len == LAST_IDX) begin
                            w_nxt     = S_COMMIT;
                            w_idx_nxt = '0;
                        end else begin
                            w_nxt = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                w_we    = 1'b1;
                w_addr  = r_idx;
                w_wdata = PAD_BYTE;
                if (r_idx == LAST_IDX) begin
                    w_nxt     = S_COMMIT;
                    w_idx_nxt = '0;
                end else begin
                    w_idx_nxt = r_idx + PTR_IN_SZ'(1);
                end
            end
            S_COMMIT: begin
                w_winc    = 1'b1;
                w_pkt_inc = 1'b1;
                w_nxt     = S_IDLE;
                w_idx_nxt = '0;
            end
            S_DROP: begin
                if (w_acc && in_sop) w_hdr_take = 1'b1;
            end
            default: w_nxt = S_IDLE;
        endcase

        // Header path shared by IDLE, an abandoning sop in LOAD, and a sop in DROP
        if (w_hdr_take) begin
            if (w_hdr_ok) begin
                w_we      = 1'b1;
                w_addr    = '0;
                w_wdata   = in_data;
                w_idx_nxt = PTR_IN_SZ'(1);
                if (w_len != 0)      w_nxt = S_LOAD;
                else if (WIDTH == 1) w_nxt = S_COMMIT;
                else                 w_nxt = S_PAD;
            end else begin
                w_drop_inc = w_drop_inc + 2'd1;
                w_nxt      = S_DROP;
                w_idx_nxt  = '0;
            end
        end
    end

`ifdef ROUTER_PKT_CHECKSUM_EN
    pkt_xor_check #(.UWIDTH(UWIDTH)) u_xor (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_hdr_take & w_hdr_ok),
        .i_en    (w_acc & ~in_sop & (r_state == S_LOAD)),
        .i_last  (r_idx == r_len),
        .i_hdr   (in_data),
        .i_data  (in_data),
        .o_bad   (w_ck_bad)
    );
`else
    assign w_ck_bad = 1'b0;
`endif

    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_live     <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            r_idx   <= w_idx_nxt;
            r_live  <= 1'b1;
            if (w_hdr_take && w_hdr_ok) r_len <= PTR_IN_SZ'(w_len);
            if (w_pkt_inc && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
        end
    end

    assign in_ready = w_ready;
    assign wbyte_we = w_we;
    assign waddr_in = w_addr;
    assign wdata    = w_wdata;
    assign winc     = w_winc;
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule
